layer_input_queue: RTL and testbench
====================================

# layer_input_queue

Parametrised input-vector queue placed between network layers, succeeding the single-slot layer latch. It captures a full `weightNo`×`dataWidth` activation vector on each rising edge of the upstream trigger (`done_in` or `first`), holds up to `DEPTH` vectors in order, and presents the oldest to the downstream layer under a valid/consume handshake. It adds overflow detection, flush, occupancy reporting and a selectable empty-output mode.

## Interface
- `weightNo`, 784, elements per vector
- `dataWidth`, 16, bits per element
- `DEPTH`, 2, vector slots (≥1; need not be a power of two)
- `HOLD_LAST`, 1, 1: `out` shows last vector when empty; 0: `out` is all-zero when empty
- `clk`  in  1  single clock, all logic on posedge
- `rst_n`  in  1  reset, synchronous, active-low
- `first`  in  1  seed trigger for the first layer
- `done_in`  in  1  upstream layer done (level)
- `flush`  in  1  synchronous queue clear
- `in`  in  weightNo*dataWidth  vector to capture
- `consume`  in  1  downstream accepts head vector
- `out`  out  weightNo*dataWidth  head vector
- `f_layer`  out  weightNo*dataWidth  identical copy of `out`
- `valid_out`  out  1  queue not empty
- `full`  out  1  count == DEPTH
- `count`  out  $clog2(DEPTH+1)  occupancy
- `overflow`  out  1  sticky: capture dropped because queue full

## Operation
- `trig = done_in | first`. Arm flag `armed`: reset 1; cleared on a capture event; set in any cycle where `trig` is 0. Capture event = `trig & armed`, i.e. one capture per rising edge of `trig`; a held-high `trig` captures once.
- Capture with `count < DEPTH` (or simultaneous pop while full): `mem[wr_ptr] <= in`, `wr_ptr` advances.
- Capture while full with no pop: vector dropped, `overflow` <= 1, pointers/count unchanged, `armed` still cleared.
- Pop = `consume & valid_out`: `rd_ptr` advances. `consume` while empty is ignored.
- Pointers wrap DEPTH-1 → 0 explicitly. `count` +1 on write only, −1 on pop only, unchanged when both.
- `out` = `mem[rd_ptr]` when `valid_out`. When empty: HOLD_LAST=1 → `mem[(rd_ptr−1) mod DEPTH]` (last popped vector; zero if none since reset/flush); HOLD_LAST=0 → 0.
- `flush`: pointers, `count`, `overflow` cleared; all `mem` zeroed; `armed` unchanged. A capture or pop in the same cycle is discarded.
- Priority: `rst_n` low > `flush` > capture/pop.
- Reset: `mem` all zero, pointers 0, `count` 0, `overflow` 0, `armed` 1 → `out`=0, `f_layer`=0, `valid_out`=0, `full`=0.

## Timing
- Capture latency 1 cycle: `trig` rises in cycle N (armed) → in cycle N+1 `count`, `valid_out`, `full` updated; if queue was empty, `out` = that `in` in cycle N+1.
- `in` is sampled only on the capture edge; later changes do not affect stored data.
- Pop: `consume` high in cycle N with `valid_out` → in cycle N+1 `out` shows next entry (or empty-mode value).
- All outputs are functions of registers only; no combinational path from any input to any output.
- Re-arm needs `trig` low for at least one cycle; back-to-back 1-cycle pulses separated by one low cycle each capture.
- Reset mid-operation discards all stored vectors in the same edge.

## Test plan
- Bench `weightNo`=4, `dataWidth`=16, `DEPTH`=2, `HOLD_LAST`=1.
- Reset then idle: `out`=0, `valid_out`=0, `count`=0, `overflow`=0; `consume`=1 for 3 cycles changes nothing.
- `first` pulse with `in`=0x0004_0003_0002_0001, then `done_in` held high 5 cycles with `in`=0xAAAA…: exactly one capture from `first`, one from `done_in` rise after `first` low a cycle → `count`=2, `full`=1, `out`=0x0004_0003_0002_0001.
- Full, third `done_in` rising edge with `in`=0x1111… → `overflow`=1, `count`=2, contents unchanged; pop twice → `out`=0xAAAA…, then empty with `out` held 0xAAAA…, `valid_out`=0.
- `count`=1, capture and `consume` same cycle → `count` stays 1, `out` = new vector next cycle; repeat 5 times to exercise pointer wrap with no data corruption.
- `count`=2, `overflow`=1, assert `flush` with capture edge → next cycle `count`=0, `overflow`=0, `out`=0; `rst_n` low mid-stream → all outputs reset values next cycle. Rerun scenario 3 with `HOLD_LAST`=0: empty `out`=0.

Source files
------------

// File: rtl/layer_input_queue.sv
// layer_input_queue
//   FIFO of full activation vectors sitting between two network layers.
//   A vector is captured once for every rising edge of the upstream trigger
//   (done_in | first). Up to DEPTH vectors are kept in order, and the oldest
//   one is shown to the downstream layer under a valid/consume handshake.
//
// Ports
//   clk, rst_n        single clock; synchronous active-low reset
//   first, done_in    capture triggers (OR'd, edge-detected internally)
//   flush             synchronous clear of queue contents and overflow flag
//   in                vector sampled on a capture edge
//   consume           downstream accepts the head vector
//   out, f_layer      head vector (identical copies)
//   valid_out, full   queue non-empty / queue holds DEPTH vectors
//   count             occupancy
//   overflow          sticky: a capture was dropped because the queue was full
module layer_input_queue #(
    parameter int weightNo  = 784,
    parameter int dataWidth = 16,
    parameter int DEPTH     = 2,
    parameter int HOLD_LAST = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              first,
    input  logic                              done_in,
    input  logic                              flush,
    input  logic [weightNo*dataWidth-1:0]     in,
    input  logic                              consume,
    output logic [weightNo*dataWidth-1:0]     out,
    output logic [weightNo*dataWidth-1:0]     f_layer,
    output logic                              valid_out,
    output logic                              full,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              overflow
);

    localparam int W  = weightNo * dataWidth;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           rd_prev;
    logic                    armed;
    logic                    trig;
    logic                    cap;
    logic                    pop;
    logic                    wr_en;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign trig      = done_in | first;
    assign cap       = trig & armed;
    assign pop       = consume & valid_out;
    // When full, a same-cycle pop frees the head slot (wr_ptr == rd_ptr),
    // so the new vector may land there.
    assign wr_en     = cap & (~full | pop);
    assign valid_out = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign rd_prev   = (rd_ptr == '0) ? PW'(DEPTH - 1) : rd_ptr - PW'(1);

    // Slot behind rd_ptr still holds the last popped vector while empty:
    // writes go to wr_ptr (== rd_ptr when empty), never to rd_prev, except
    // for DEPTH==1 where the write makes the queue non-empty anyway.
    always_comb begin
        out = '0;
        if (valid_out)
            out = mem[rd_ptr];
        else if (HOLD_LAST != 0)
            out = mem[rd_prev];
    end

    assign f_layer = out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            armed    <= 1'b1;
        end else begin
            // Edge detector runs independently of flush.
            if (!trig)
                armed <= 1'b1;
            else if (cap)
                armed <= 1'b0;

            if (flush) begin
                mem      <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr_en) begin
                    mem[wr_ptr] <= in;
                    wr_ptr      <= nxt(wr_ptr);
                end else if (cap) begin
                    overflow <= 1'b1;
                end
                if (pop)
                    rd_ptr <= nxt(rd_ptr);
                if (wr_en && !pop)
                    count <= count + CW'(1);
                else if (!wr_en && pop)
                    count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_layer_input_queue.sv
// tb_layer_input_queue
//   Drives two queue instances (HOLD_LAST=1 and HOLD_LAST=0) with the same
//   stimulus and compares them every cycle against a queue-based model,
//   plus fixed expected values for the directed scenarios.
module tb_layer_input_queue;

    localparam int WN    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 2;
    localparam int W     = WN * DW;

    logic          clk = 1'b0;
    logic          rst_n, first, done_in, flush, consume;
    logic [W-1:0]  in_v;

    logic [W-1:0]  out_h, fl_h, out_z, fl_z;
    logic          v_h, f_h, o_h, v_z, f_z, o_z;
    logic [1:0]    c_h, c_z;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [W-1:0] mq[$];
    logic [W-1:0] m_last;
    bit           m_armed;
    bit           m_ovf;

    always #5 clk = ~clk;

    layer_input_queue #(.weightNo(WN), .dataWidth(DW), .DEPTH(DEPTH), .HOLD_LAST(1)) u_hold (
        .clk(clk), .rst_n(rst_n), .first(first), .done_in(done_in), .flush(flush),
        .in(in_v), .consume(consume), .out(out_h), .f_layer(fl_h), .valid_out(v_h),
        .full(f_h), .count(c_h), .overflow(o_h));

    layer_input_queue #(.weightNo(WN), .dataWidth(DW), .DEPTH(DEPTH), .HOLD_LAST(0)) u_zero (
        .clk(clk), .rst_n(rst_n), .first(first), .done_in(done_in), .flush(flush),
        .in(in_v), .consume(consume), .out(out_z), .f_layer(fl_z), .valid_out(v_z),
        .full(f_z), .count(c_z), .overflow(o_z));

    // Advance the model with the inputs currently applied, then clock.
    task automatic model_update();
        bit trg, cp, pp, wok;
        if (!rst_n) begin
            mq.delete(); m_last = '0; m_ovf = 0; m_armed = 1;
            return;
        end
        trg = done_in | first;
        cp  = trg && m_armed;
        pp  = consume && (mq.size() > 0);
        if (!trg) m_armed = 1;
        else if (cp) m_armed = 0;
        if (flush) begin
            mq.delete(); m_last = '0; m_ovf = 0;
            return;
        end
        wok = cp && ((mq.size() < DEPTH) || pp);
        if (pp) m_last = mq.pop_front();
        if (wok) mq.push_back(in_v);
        else if (cp) m_ovf = 1;
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [265:0] act();
        return {out_h, fl_h, v_h, f_h, c_h, o_h, out_z, fl_z, v_z, f_z, c_z, o_z};
    endfunction

    function automatic logic [265:0] exp_vec();
        logic [W-1:0] h, z;
        logic [1:0]   c;
        logic         v, f;
        c = 2'(mq.size());
        v = (mq.size() > 0);
        f = (mq.size() == DEPTH);
        if (v) begin h = mq[0]; z = mq[0]; end
        else   begin h = m_last; z = '0; end
        return {h, h, v, f, c, m_ovf, z, z, v, f, c, m_ovf};
    endfunction

    task automatic capture(input logic [W-1:0] v);
        in_v = v; done_in = 1; tick();
        done_in = 0; tick();
    endtask

    task automatic test_reset();
        rst_n = 0; tick(); tick();
        rst_n = 1; tick();
        n_checks++;
        if (act() !== exp_vec()) begin n_fail++; $display("FAIL reset_model: got %h expected %h", act(), exp_vec()); end
        n_checks++;
        if ({out_h, v_h, c_h, o_h, out_z} !== {64'h0, 1'b0, 2'd0, 1'b0, 64'h0}) begin
            n_fail++; $display("FAIL reset_const: got %h/%b/%0d/%b", out_h, v_h, c_h, o_h);
        end
        consume = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({out_h, v_h, c_h, o_h} !== {64'h0, 1'b0, 2'd0, 1'b0}) begin
                n_fail++; $display("FAIL idle_consume: got %h/%b/%0d/%b expected 0/0/0/0", out_h, v_h, c_h, o_h);
            end
        end
        consume = 0;
    endtask

    task automatic test_capture_once();
        in_v = 64'h0004_0003_0002_0001; first = 1; tick();
        n_checks++;
        if (act() !== exp_vec()) begin n_fail++; $display("FAIL first_cap: got %h expected %h", act(), exp_vec()); end
        first = 0; in_v = {$urandom, $urandom}; tick();
        done_in = 1; in_v = {4{16'hAAAA}};
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (act() !== exp_vec()) begin n_fail++; $display("FAIL held_trig: got %h expected %h", act(), exp_vec()); end
            in_v = {$urandom, $urandom};
        end
        n_checks++;
        if ({c_h, f_h, o_h, out_h} !== {2'd2, 1'b1, 1'b0, 64'h0004_0003_0002_0001}) begin
            n_fail++; $display("FAIL two_caps: got count=%0d full=%b ovf=%b out=%h", c_h, f_h, o_h, out_h);
        end
        done_in = 0;
    endtask

    task automatic test_overflow();
        tick();
        done_in = 1; in_v = {4{16'h1111}}; tick();
        done_in = 0;
        n_checks++;
        if ({o_h, c_h, out_h} !== {1'b1, 2'd2, 64'h0004_0003_0002_0001}) begin
            n_fail++; $display("FAIL overflow: got ovf=%b count=%0d out=%h", o_h, c_h, out_h);
        end
        consume = 1; tick();
        n_checks++;
        if (out_h !== {4{16'hAAAA}}) begin n_fail++; $display("FAIL pop1: got %h expected %h", out_h, {4{16'hAAAA}}); end
        tick();
        consume = 0;
        n_checks++;
        if ({v_h, out_h, v_z, out_z} !== {1'b0, {4{16'hAAAA}}, 1'b0, 64'h0}) begin
            n_fail++; $display("FAIL empty_mode: got v=%b hold=%h zero=%h", v_h, out_h, out_z);
        end
        n_checks++;
        if (act() !== exp_vec()) begin n_fail++; $display("FAIL overflow_model: got %h expected %h", act(), exp_vec()); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] v;
        capture({$urandom, $urandom});
        for (int i = 0; i < 5; i++) begin
            v = {$urandom, $urandom};
            in_v = v; done_in = 1; consume = 1; tick();
            done_in = 0; consume = 0;
            n_checks++;
            if ({c_h, out_h} !== {2'd1, v}) begin
                n_fail++; $display("FAIL cap_pop: got count=%0d out=%h expected 1 %h", c_h, out_h, v);
            end
            tick();
            n_checks++;
            if (act() !== exp_vec()) begin n_fail++; $display("FAIL cap_pop_model: got %h expected %h", act(), exp_vec()); end
        end
    endtask

    task automatic test_flush();
        capture({$urandom, $urandom});
        capture({$urandom, $urandom});
        n_checks++;
        if ({c_h, o_h} !== {2'd2, 1'b1}) begin n_fail++; $display("FAIL pre_flush: got count=%0d ovf=%b", c_h, o_h); end
        flush = 1; done_in = 1; in_v = {$urandom, $urandom}; tick();
        flush = 0; done_in = 0;
        n_checks++;
        if ({c_h, o_h, out_h, v_h} !== {2'd0, 1'b0, 64'h0, 1'b0}) begin
            n_fail++; $display("FAIL flush: got count=%0d ovf=%b out=%h v=%b", c_h, o_h, out_h, v_h);
        end
        tick();
        n_checks++;
        if (act() !== exp_vec()) begin n_fail++; $display("FAIL flush_model: got %h expected %h", act(), exp_vec()); end
    endtask

    task automatic test_mid_reset();
        capture({$urandom, $urandom});
        capture({$urandom, $urandom});
        rst_n = 0; done_in = 1; consume = 1; tick();
        rst_n = 1; done_in = 0; consume = 0;
        n_checks++;
        if ({out_h, fl_h, v_h, f_h, c_h, o_h} !== {64'h0, 64'h0, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            n_fail++; $display("FAIL mid_reset: got out=%h v=%b full=%b count=%0d ovf=%b", out_h, v_h, f_h, c_h, o_h);
        end
        tick();
        n_checks++;
        if (act() !== exp_vec()) begin n_fail++; $display("FAIL mid_reset_model: got %h expected %h", act(), exp_vec()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            first   = ($urandom_range(7) == 0);
            done_in = ($urandom_range(2) == 0);
            consume = ($urandom_range(2) == 0);
            flush   = ($urandom_range(39) == 0);
            rst_n   = ($urandom_range(149) != 0);
            in_v    = {$urandom, $urandom};
            tick();
            n_checks++;
            if (act() !== exp_vec()) begin n_fail++; $display("FAIL random cyc %0d: got %h expected %h", i, act(), exp_vec()); end
        end
        first = 0; done_in = 0; consume = 0; flush = 0; rst_n = 1;
    endtask

    initial begin
        rst_n = 0; first = 0; done_in = 0; flush = 0; consume = 0; in_v = '0;
        m_last = '0; m_armed = 1; m_ovf = 0;
        test_reset();
        test_capture_once();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
